fifo_flex: RTL

- Parametrised synchronous FIFO; successor to the basic full/empty FIFO.
- Adds the following over the basic FIFO:
  - non-power-of-2 depth
  - valid/ready on both sides
  - selectable first-word-fall-through (FWFT) or registered-read mode
  - programmable almost-full/almost-empty thresholds
  - fill count
  - sticky overflow/underflow flags
  - synchronous clear
- Sits between producer/consumer blocks on the SoC datapath, in the same clock domain.

---
 rtl/fifo_flex.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fifo_flex.sv
// fifo_flex: same-clock FIFO with valid/ready on both sides, any depth >= 2,
// FWFT or registered read, threshold flags, fill count and sticky errors.
module fifo_flex #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 3,
    parameter int FWFT     = 1,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             w_valid,
    output logic             w_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             r_ready,
    output logic             r_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             underflow
);

    localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr_nxt;

    logic push;
    logic pop;

    // Status flags come straight from the registered count.
    assign fifo_full    = (count == CNT_FULL);
    assign fifo_empty   = (count == '0);
    assign almost_full  = (count >= CNT_AF);
    assign almost_empty = (count <= CNT_AE);
    assign w_ready      = !fifo_full;

    // A full FIFO refuses writes even when a pop lands in the same cycle.
    assign push = w_valid && !fifo_full && !clear;

    // Pointers wrap explicitly so any depth works, not just powers of two.
    assign wr_ptr_nxt = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
    assign rd_ptr_nxt = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Write pointer advances on every accepted word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr_nxt;
        end
    end

    // Read pointer advances on every popped word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr_nxt;
        end
    end

    // Occupancy: push and pop together leave it unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; clear wins and suppresses setting them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_valid && fifo_full) begin
                overflow <= 1'b1;
            end
            if (r_ready && fifo_empty) begin
                underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft

            // Head word is presented combinationally while not empty.
            assign r_valid  = !fifo_empty;
            assign data_out = fifo_empty ? '0 : mem[rd_ptr];
            assign pop      = !fifo_empty && r_ready && !clear;

        end else begin : g_reg

            logic [WIDTH-1:0] dout_q;
            logic             rvalid_q;

            assign pop      = r_ready && !fifo_empty && !clear;
            assign r_valid  = rvalid_q;
            assign data_out = dout_q;

            // Registered read: word lands one edge after the request and
            // is then held until the next pop.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    dout_q   <= '0;
                    rvalid_q <= 1'b0;
                end else if (clear) begin
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= pop;
                    if (pop) begin
                        dout_q <= mem[rd_ptr];
                    end
                end
            end

        end
    endgenerate

endmodule
